sc_lifecontroller: RTL



---
 rtl/sc_lifecontroller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sc_lifecontroller.sv
// sc_lifecontroller -- life-loss sequencer in front of the live counter.
// Converts the collision level into one CUENTA decrement pulse per hit, runs a
// respawn/invulnerability window after each hit and raises a sticky game-over
// once the fed-back life count reaches zero.
// Optional build macro: SC_LIFECTRL_DEBOUNCE_EN -- replaces rising-edge hit
// detection with a DEBOUNCE_CYCLES-long saturating debounce counter.
module sc_lifecontroller #(
    parameter int unsigned GRACE_CYCLES    = 50000000,
    parameter int unsigned TIMER_WIDTH     = 26,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       SC_LIVECOUNTER_CLOCK_50,
    input  logic       SC_LIVECOUNTER_RESET_InHigh,
    input  logic       SC_LIFECTRL_COLLISION_In,
    input  logic [3:0] SC_LIFECTRL_LIVES_InBUS,
    output logic       SC_LIFECTRL_CUENTA_Out,
    output logic       SC_LIFECTRL_RESPAWN_Out,
    output logic       SC_LIFECTRL_INVULN_Out,
    output logic       SC_LIFECTRL_GAMEOVER_Out
);

    // Reject parameter sets the grace timer or debounce counter cannot represent.
    if (GRACE_CYCLES < 1 || GRACE_CYCLES >= (64'd1 << TIMER_WIDTH) || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("sc_lifecontroller: GRACE_CYCLES/DEBOUNCE_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        ST_PLAY,
        ST_HIT,
        ST_CHECK,
        ST_RESPAWN,
        ST_GAMEOVER
    } state_t;

    // Timer counts GRACE_CYCLES-1 down to 0, so the window lasts GRACE_CYCLES cycles.
    localparam logic [TIMER_WIDTH-1:0] GRACE_LOAD = TIMER_WIDTH'(GRACE_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   hit;
    logic                   no_lives;

    assign no_lives = (SC_LIFECTRL_LIVES_InBUS == 4'd0);

`ifdef SC_LIFECTRL_DEBOUNCE_EN
    localparam int unsigned      DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_HIT = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_count;

    // Saturating run-length of high collision samples; frozen at 0 while invulnerable or dead.
    always_ff @(posedge SC_LIVECOUNTER_CLOCK_50 or posedge SC_LIVECOUNTER_RESET_InHigh) begin
        if (SC_LIVECOUNTER_RESET_InHigh) begin
            db_count <= '0;
        end else if (!SC_LIFECTRL_COLLISION_In || state == ST_RESPAWN || state == ST_GAMEOVER) begin
            db_count <= '0;
        end else if (db_count != DB_MAX) begin
            db_count <= db_count + 1'b1;
        end
    end

    // A hit is the single cycle in which the run length reaches DEBOUNCE_CYCLES.
    assign hit = SC_LIFECTRL_COLLISION_In && (db_count == DB_HIT);
`else
    logic collision_q;

    // Collision history: last cycle's sample, kept updating in every state.
    always_ff @(posedge SC_LIVECOUNTER_CLOCK_50 or posedge SC_LIVECOUNTER_RESET_InHigh) begin
        if (SC_LIVECOUNTER_RESET_InHigh) begin
            collision_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
            collision_q <= SC_LIFECTRL_COLLISION_In;
        end
    end

    // Rising edge only: a collision held high never counts twice.
    assign hit = SC_LIFECTRL_COLLISION_In && !collision_q;
`endif

    // State register.
    always_ff @(posedge SC_LIVECOUNTER_CLOCK_50 or posedge SC_LIVECOUNTER_RESET_InHigh) begin
        if (SC_LIVECOUNTER_RESET_InHigh) begin
            state <= ST_PLAY;
        end else begin
            state <= state_next;
        end
    end

    // Grace timer: loaded on entry to RESPAWN, counts down to 0 without wrapping.
    always_ff @(posedge SC_LIVECOUNTER_CLOCK_50 or posedge SC_LIVECOUNTER_RESET_InHigh) begin
        if (SC_LIVECOUNTER_RESET_InHigh) begin
            timer <= '0;
        end else if (state == ST_CHECK && state_next == ST_RESPAWN) begin
            timer <= GRACE_LOAD;
        end else if (state == ST_RESPAWN && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    // Next-state decode; hits are only honoured in PLAY.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_PLAY: begin
                if (no_lives) begin
                    state_next = ST_GAMEOVER;
                end else if (hit) begin
                    state_next = ST_HIT;
                end
            end
            ST_HIT: begin
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                // The live counter has already applied the decrement here.
                state_next = no_lives ? ST_GAMEOVER : ST_RESPAWN;
            end
            ST_RESPAWN: begin
                if (timer == '0) begin
                    state_next = ST_PLAY;
                end
            end
            ST_GAMEOVER: begin
                state_next = ST_GAMEOVER;
            end
            default: begin
                state_next = ST_PLAY;
            end
        endcase
    end

    // Moore output decode from registered state and timer only.
    always_comb begin
        SC_LIFECTRL_CUENTA_Out   = (state == ST_HIT);
        SC_LIFECTRL_RESPAWN_Out  = (state == ST_RESPAWN) && (timer == GRACE_LOAD);
        SC_LIFECTRL_INVULN_Out   = (state == ST_RESPAWN);
        SC_LIFECTRL_GAMEOVER_Out = (state == ST_GAMEOVER);
    end

endmodule
